pulse_train_sequencer: RTL and testbench

//  Control stage that sits directly upstream of the interval counter. It drives the counter's

---
 rtl/pulse_train_sequencer_if.sv | 37 +++
 rtl/pulse_train_sequencer.sv | 117 +++++++++++
 tb/tb_pulse_train_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_train_sequencer_if.sv
// rtl/pulse_train_sequencer_if.sv - control/counter handshake bundle for the pulse train sequencer
interface pulse_train_sequencer_if #(
    parameter int NUM_PULSES = 4
);
    localparam int IDX_W = $clog2(NUM_PULSES + 1);

    logic             start_i;
    logic             abort_i;
    logic             counter_finished_i;
    logic             counter_enable_o;
    logic             pulse_o;
    logic [IDX_W-1:0] pulse_idx_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i,
        output abort_i,
        output counter_finished_i,
        input  counter_enable_o,
        input  pulse_o,
        input  pulse_idx_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  abort_i,
        input  counter_finished_i,
        output counter_enable_o,
        output pulse_o,
        output pulse_idx_o,
        output busy_o,
        output done_o
    );
endinterface

// File: rtl/pulse_train_sequencer.sv
// rtl/pulse_train_sequencer.sv - drives an interval counter to emit NUM_PULSES high/low pulse pairs
module pulse_train_sequencer #(
    parameter int NUM_PULSES = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    pulse_train_sequencer_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_PULSES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PULSES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [2:0]       r_state;
    logic             r_phase_low;
    logic [IDX_W-1:0] r_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_enable;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_state_nxt;
    logic             w_phase_low_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [GAP_W-1:0] w_gap_cnt_nxt;

    // Abort outranks everything; finished is only honoured in RUN because the
    // counter's flag is stale during ARM and GAP.
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_low_nxt = r_phase_low;
        w_idx_nxt       = r_idx;
        w_gap_cnt_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    w_state_nxt     = S_ARM;
                    w_phase_low_nxt = 1'b0;
                    w_idx_nxt       = '0;
                end
            end
            S_ARM: begin
                w_state_nxt = bus.abort_i ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (bus.abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.counter_finished_i) begin
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = '0;
                end
            end
            S_GAP: begin
                if (bus.abort_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap_cnt == GAP_LAST) begin
                    if (!r_phase_low) begin
                        w_phase_low_nxt = 1'b1;
                        w_state_nxt     = S_ARM;
                    end else if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt       = r_idx + IDX_W'(1);
                        w_phase_low_nxt = 1'b0;
                        w_state_nxt     = S_ARM;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= S_IDLE;
            r_phase_low <= 1'b0;
            r_idx       <= '0;
            r_gap_cnt   <= '0;
            r_enable    <= 1'b0;
            r_pulse     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase_low <= w_phase_low_nxt;
            r_idx       <= w_idx_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_enable    <= (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);
            r_pulse     <= !w_phase_low_nxt && ((w_state_nxt == S_ARM) || (w_state_nxt == S_RUN));
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.counter_enable_o = r_enable;
    assign bus.pulse_o          = r_pulse;
    assign bus.pulse_idx_o      = r_idx;
    assign bus.busy_o           = r_busy;
    assign bus.done_o           = r_done;
endmodule

// File: tb/tb_pulse_train_sequencer.sv
// tb/tb_pulse_train_sequencer.sv - randomized self-checking bench with a behavioural interval counter
module tb_pulse_train_sequencer;
    localparam int NP   = 2;
    localparam int GAPC = 2;
    localparam int M    = 3;
    localparam int WIN  = M + 3;
    localparam int PH   = WIN + GAPC;
    localparam int LEN  = 2 * NP * PH;

    localparam logic [5:0] MASK_ALL  = 6'b111111;
    localparam logic [5:0] MASK_NIDX = 6'b110011;

    logic clk = 1'b0;
    logic rst_n;
    logic fin_force;
    logic cnt_fin;
    logic en_d;
    int   cnt;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pulse_train_sequencer_if #(.NUM_PULSES(NP)) bus();

    pulse_train_sequencer #(.NUM_PULSES(NP), .GAP_CYCLES(GAPC)) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    // Interval counter: clears on enable rise, counts M+1 cycles, then holds finished.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_fin <= 1'b0;
            en_d    <= 1'b0;
            cnt     <= 0;
        end else begin
            en_d <= bus.counter_enable_o;
            if (bus.counter_enable_o) begin
                if (!en_d) begin
                    cnt     <= 0;
                    cnt_fin <= 1'b0;
                end else if (cnt == M) begin
                    cnt_fin <= 1'b1;
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    assign bus.counter_finished_i = cnt_fin | fin_force;

    function automatic logic [5:0] obs();
        return {bus.counter_enable_o, bus.pulse_o, bus.pulse_idx_o, bus.busy_o, bus.done_o};
    endfunction

    // Expected {enable, pulse, idx, busy, done} t cycles after the first busy cycle.
    function automatic logic [5:0] model(input int t);
        int         ph;
        int         w;
        logic       en;
        logic       pl;
        logic [1:0] ix;
        if (t < LEN) begin
            ph = t / PH;
            w  = t % PH;
            en = (w < WIN);
            pl = en && (ph % 2 == 0);
            ix = 2'(ph / 2);
            return {en, pl, ix, 1'b1, 1'b0};
        end else if (t == LEN) begin
            return {1'b0, 1'b0, 2'(NP - 1), 1'b1, 1'b1};
        end
        return {1'b0, 1'b0, 2'(NP - 1), 1'b0, 1'b0};
    endfunction

    task automatic do_start();
        bus.start_i = 1'b1;
        bus.abort_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start_i = 1'b1;
        bus.abort_i = 1'b0;
        fin_force   = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs() !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_hold got=%b exp=%b", obs(), 6'b0);
        end
        bus.start_i = 1'b0;
        rst_n       = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs() !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_release got=%b exp=%b", obs(), 6'b0);
        end
    endtask

    task automatic test_nominal();
        int dones;
        dones = 0;
        do_start();
        for (int t = 0; t <= LEN + 2; t++) begin
            n_cmp++;
            if (obs() !== model(t)) begin
                n_bad++;
                $display("FAIL nominal t=%0d got=%b exp=%b", t, obs(), model(t));
            end
            if (bus.done_o === 1'b1) dones++;
            @(negedge clk);
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL nominal_done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        do_start();
        for (int t = 0; t <= PH + 2; t++) begin
            n_cmp++;
            if (obs() !== model(t)) begin
                n_bad++;
                $display("FAIL abort_pre t=%0d got=%b exp=%b", t, obs(), model(t));
            end
            @(negedge clk);
        end
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        n_cmp++;
        if ((obs() & MASK_NIDX) !== 6'b0) begin
            n_bad++;
            $display("FAIL abort_idle got=%b exp=%b", obs() & MASK_NIDX, 6'b0);
        end
        for (int t = 0; t < 40; t++) begin
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) dones++;
            @(negedge clk);
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done got=%0d exp=0", dones);
        end
        do_start();
        for (int t = 0; t < 4; t++) begin
            n_cmp++;
            if (obs() !== model(t)) begin
                n_bad++;
                $display("FAIL abort_restart t=%0d got=%b exp=%b", t, obs(), model(t));
            end
            @(negedge clk);
        end
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int dones;
        dones       = 0;
        bus.start_i = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 2 * (LEN + 2); t++) begin
            n_cmp++;
            if (obs() !== model(t % (LEN + 2))) begin
                n_bad++;
                $display("FAIL start_busy t=%0d got=%b exp=%b", t, obs(), model(t % (LEN + 2)));
            end
            if (bus.done_o === 1'b1) dones++;
            if (t == 2 * (LEN + 2) - 1) bus.start_i = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (dones !== 2) begin
            n_bad++;
            $display("FAIL start_busy_done_count got=%0d exp=2", dones);
        end
    endtask

    task automatic test_finished_collision();
        do_start();
        fin_force = 1'b1;
        n_cmp++;
        if (obs() !== model(0)) begin
            n_bad++;
            $display("FAIL coll_arm got=%b exp=%b", obs(), model(0));
        end
        @(negedge clk);
        fin_force = 1'b0;
        for (int t = 1; t < WIN; t++) begin
            n_cmp++;
            if (obs() !== model(t)) begin
                n_bad++;
                $display("FAIL coll_run t=%0d got=%b exp=%b", t, obs(), model(t));
            end
            if (t == WIN - 1) begin
                bus.abort_i = 1'b1;
                fin_force   = 1'b1;
            end
            @(negedge clk);
        end
        bus.abort_i = 1'b0;
        fin_force   = 1'b0;
        for (int t = 0; t < 2; t++) begin
            n_cmp++;
            if ((obs() & MASK_NIDX) !== 6'b0) begin
                n_bad++;
                $display("FAIL coll_abort_fin t=%0d got=%b exp=%b", t, obs() & MASK_NIDX, 6'b0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        do_start();
        for (int t = 0; t <= WIN; t++) begin
            n_cmp++;
            if (obs() !== model(t)) begin
                n_bad++;
                $display("FAIL areset_pre t=%0d got=%b exp=%b", t, obs(), model(t));
            end
            if (t < WIN) @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 6'b0) begin
            n_bad++;
            $display("FAIL areset_immediate got=%b exp=%b", obs(), 6'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs() !== 6'b0) begin
            n_bad++;
            $display("FAIL areset_after got=%b exp=%b", obs(), 6'b0);
        end
    endtask

    task automatic test_random();
        int  idle;
        int  ab;
        bit  both;
        for (int it = 0; it < 10; it++) begin
            idle = $urandom_range(1, 3);
            for (int k = 0; k < idle; k++) begin
                both        = 1'($urandom_range(0, 1));
                bus.start_i = both;
                bus.abort_i = both;
                @(negedge clk);
                n_cmp++;
                if ((obs() & 6'b000011) !== 6'b0) begin
                    n_bad++;
                    $display("FAIL rand_idle it=%0d got=%b exp=%b", it, obs() & 6'b000011, 6'b0);
                end
            end
            do_start();
            ab = $urandom_range(0, 2 * LEN);
            for (int t = 0; t <= LEN + 1; t++) begin
                n_cmp++;
                if (obs() !== model(t)) begin
                    n_bad++;
                    $display("FAIL rand_seq it=%0d t=%0d got=%b exp=%b", it, t, obs(), model(t));
                end
                bus.start_i = (t < LEN) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (t == ab) begin
                    bus.abort_i = 1'b1;
                    @(negedge clk);
                    bus.abort_i = 1'b0;
                    bus.start_i = 1'b0;
                    n_cmp++;
                    if ((obs() & MASK_NIDX) !== 6'b0) begin
                        n_bad++;
                        $display("FAIL rand_abort it=%0d t=%0d got=%b exp=%b", it, t, obs() & MASK_NIDX, 6'b0);
                    end
                    break;
                end
                @(negedge clk);
            end
            bus.start_i = 1'b0;
            bus.abort_i = 1'b0;
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        fin_force   = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        test_reset();
        test_nominal();
        test_abort();
        test_start_while_busy();
        test_finished_collision();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
